// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on stall/flush, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic             ALUSrc_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [31:0]      RS1data_i,
    input  logic [31:0]      RS2data_i,
    input  logic [31:0]      Imm_i,
    input  logic [9:0]       Funct_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic [4:0]       RDaddr_i,
    output logic             EX_RegWrite_o,
    output logic             EX_MemtoReg_o,
    output logic             EX_MemRead_o,
    output logic             EX_MemWrite_o,
    output logic             EX_ALUSrc_o,
    output logic [1:0]       EX_ALUOp_o,
    output logic [31:0]      EX_RS1data_o,
    output logic [31:0]      EX_RS2data_o,
    output logic [31:0]      EX_Imm_o,
    output logic [9:0]       EX_Funct_o,
    output logic [4:0]       EX_RS1addr_o,
    output logic [4:0]       EX_RS2addr_o,
    output logic [4:0]       EX_RDaddr_o,
    output logic             EX_valid_o,
    output logic             stall_o,
    output logic             load_use_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // All EX fields travel as one packed word; a bubble is simply all zeros.
    localparam int FW = 128;

    logic [FW-1:0]    id_fields;
    logic [FW-1:0]    ex_fields_q, ex_fields_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             bubble;

    assign id_fields = {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i,
                        ALUOp_i, RS1data_i, RS2data_i, Imm_i, Funct_i,
                        RS1addr_i, RS2addr_i, RDaddr_i};

    assign {EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o,
            EX_ALUOp_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o, EX_Funct_o,
            EX_RS1addr_o, EX_RS2addr_o, EX_RDaddr_o} = ex_fields_q;

    assign EX_valid_o  = ex_valid_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign load_use_o  = load_use;
    assign stall_o     = load_use | hold_i;

    // Load-use hazard: uses only registered EX state and current ID inputs,
    // so there is no loop through stall_o. rs2 is always compared.
    always_comb begin
        load_use = valid_i & ex_valid_q & EX_MemRead_o & (EX_RDaddr_o != 5'd0) &
                   ((EX_RDaddr_o == RS1addr_i) | (EX_RDaddr_o == RS2addr_i));
    end

    // Next-state: hold freezes everything; otherwise capture or insert a bubble.
    always_comb begin
        ex_fields_d = ex_fields_q;
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        bubble      = flush_i | load_use | ~valid_i;
        if (!hold_i) begin
            if (bubble) begin
                ex_fields_d = '0;
                ex_valid_d  = 1'b0;
            end else begin
                ex_fields_d = id_fields;
                ex_valid_d  = 1'b1;
            end
            // Counters saturate at all-ones instead of wrapping.
            if (load_use && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_i && valid_i && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset to an empty (bubble) EX stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_fields_q <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_fields_q <= ex_fields_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (CNT_W=4): reset, pass-through,
// load-use stall, x0 exemption, flush+hazard, hold freeze, counter saturation.
module tb_id_ex_stage;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_i, valid_i, flush_i, hold_i;
    logic RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] RS1data_i, RS2data_i, Imm_i;
    logic [9:0]  Funct_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
    logic EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o;
    logic [1:0]  EX_ALUOp_o;
    logic [31:0] EX_RS1data_o, EX_RS2data_o, EX_Imm_o;
    logic [9:0]  EX_Funct_o;
    logic [4:0]  EX_RS1addr_o, EX_RS2addr_o, EX_RDaddr_o;
    logic EX_valid_o, stall_o, load_use_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    logic [127:0] id_bus, ex_bus, exp_add, exp_x;
    int n_vec = 0;
    int n_err = 0;
    int hits;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i), .hold_i(hold_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .Funct_i(Funct_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .EX_RegWrite_o(EX_RegWrite_o), .EX_MemtoReg_o(EX_MemtoReg_o),
        .EX_MemRead_o(EX_MemRead_o), .EX_MemWrite_o(EX_MemWrite_o),
        .EX_ALUSrc_o(EX_ALUSrc_o), .EX_ALUOp_o(EX_ALUOp_o),
        .EX_RS1data_o(EX_RS1data_o), .EX_RS2data_o(EX_RS2data_o), .EX_Imm_o(EX_Imm_o),
        .EX_Funct_o(EX_Funct_o), .EX_RS1addr_o(EX_RS1addr_o), .EX_RS2addr_o(EX_RS2addr_o),
        .EX_RDaddr_o(EX_RDaddr_o), .EX_valid_o(EX_valid_o), .stall_o(stall_o),
        .load_use_o(load_use_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Stimulus word (what the bench drove) and observed EX word, same field order.
    assign id_bus = {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
                     RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i, RDaddr_i};
    assign ex_bus = {EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o,
                     EX_ALUSrc_o, EX_ALUOp_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o,
                     EX_Funct_o, EX_RS1addr_o, EX_RS2addr_o, EX_RDaddr_o};

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr, input logic mr,
                         input logic mw, input logic as, input logic [1:0] op,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [9:0] fn, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd);
        valid_i = v; RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
        ALUSrc_i = as; ALUOp_i = op; RS1data_i = d1; RS2data_i = d2; Imm_i = imm;
        Funct_i = fn; RS1addr_i = r1; RS2addr_i = r2; RDaddr_i = rd;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_i = 1'($urandom); hold_i = 1'($urandom);
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, 10'($urandom),
              5'($urandom), 5'($urandom), 5'($urandom));
        tick();
        tick();
        rst_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check_vec("rst_ex_fields", ex_bus, 128'd0);
        check_vec("rst_ex_valid", 128'(EX_valid_o), 128'd0);
        check_vec("rst_stall_cnt", 128'(stall_cnt_o), 128'd0);
        check_vec("rst_flush_cnt", 128'(flush_cnt_o), 128'd0);
        check_vec("rst_load_use", 128'(load_use_o), 128'd0);
    endtask

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tick();
        do_reset();

        // Pass-through ADD x3 = 5 + 7
        drive(1, 1, 0, 0, 0, 0, 2'b10, 32'd5, 32'd7, 32'd0, 10'd0, 5'd1, 5'd2, 5'd3);
        exp_add = id_bus;
        check_vec("add_stall", 128'(stall_o), 128'd0);
        tick();
        check_vec("add_ex_fields", ex_bus, exp_add);
        check_vec("add_ex_valid", 128'(EX_valid_o), 128'd1);

        // lw x5, 8(x1) then add x6, x5, x1
        drive(1, 1, 1, 1, 0, 1, 2'b00, 32'd100, 32'd0, 32'd8, 10'h002, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1, 1, 0, 0, 0, 0, 2'b10, 32'd11, 32'd22, 32'd0, 10'd0, 5'd5, 5'd1, 5'd6);
        exp_add = id_bus;
        check_vec("lu_load_use", 128'(load_use_o), 128'd1);
        check_vec("lu_stall", 128'(stall_o), 128'd1);
        tick();
        check_vec("lu_bubble_fields", ex_bus, 128'd0);
        check_vec("lu_bubble_valid", 128'(EX_valid_o), 128'd0);
        check_vec("lu_stall_cnt", 128'(stall_cnt_o), 128'd1);
        check_vec("lu_load_use_drop", 128'(load_use_o), 128'd0);
        tick();
        check_vec("lu_add_captured", ex_bus, exp_add);
        check_vec("lu_add_valid", 128'(EX_valid_o), 128'd1);
        check_vec("lu_stall_cnt_hold", 128'(stall_cnt_o), 128'd1);

        // lw x0 then add x6, x0, x0: no hazard on x0
        drive(1, 1, 1, 1, 0, 1, 2'b00, 32'd0, 32'd0, 32'd4, 10'h002, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 2'b10, 32'd0, 32'd0, 32'd0, 10'd0, 5'd0, 5'd0, 5'd6);
        exp_add = id_bus;
        check_vec("x0_load_use", 128'(load_use_o), 128'd0);
        tick();
        check_vec("x0_add_captured", ex_bus, exp_add);

        // Flush coinciding with a load-use hazard
        do_reset();
        drive(1, 1, 1, 1, 0, 1, 2'b00, 32'd100, 32'd0, 32'd8, 10'h002, 5'd1, 5'd0, 5'd5);
        tick();
        flush_i = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 2'b10, 32'd11, 32'd22, 32'd0, 10'd0, 5'd5, 5'd1, 5'd6);
        check_vec("fl_load_use", 128'(load_use_o), 128'd1);
        tick();
        flush_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check_vec("fl_bubble_fields", ex_bus, 128'd0);
        check_vec("fl_flush_cnt", 128'(flush_cnt_o), 128'd1);
        check_vec("fl_stall_cnt", 128'(stall_cnt_o), 128'd1);
        tick();
        check_vec("fl_not_recaptured", 128'(EX_valid_o), 128'd0);

        // Hold: EX frozen, counters unchanged even with flush asserted
        drive(1, 1, 0, 0, 1, 1, 2'b01, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0000_0F00,
              10'h155, 5'd2, 5'd3, 5'd7);
        exp_x = id_bus;
        tick();
        check_vec("hd_x_captured", ex_bus, exp_x);
        hold_i = 1'b1; flush_i = 1'b1;
        drive(1, 0, 1, 1, 0, 0, 2'b11, 32'd1, 32'd2, 32'd3, 10'h3FF, 5'd7, 5'd7, 5'd9);
        check_vec("hd_stall", 128'(stall_o), 128'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec($sformatf("hd_frozen_%0d", i), ex_bus, exp_x);
            check_vec($sformatf("hd_valid_%0d", i), 128'(EX_valid_o), 128'd1);
            check_vec($sformatf("hd_stall_cnt_%0d", i), 128'(stall_cnt_o), 128'd1);
            check_vec($sformatf("hd_flush_cnt_%0d", i), 128'(flush_cnt_o), 128'd1);
        end
        hold_i = 1'b0; flush_i = 1'b0;

        // Saturation: lw x5,(x5) repeated gives a hazard every other cycle
        do_reset();
        drive(1, 1, 1, 1, 0, 1, 2'b00, 32'd0, 32'd0, 32'd0, 10'h002, 5'd5, 5'd0, 5'd5);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (load_use_o) hits++;
            tick();
        end
        check_vec("sat_hazard_count", 128'(hits), 128'd20);
        check_vec("sat_stall_cnt", 128'(stall_cnt_o), 128'd15);
        check_vec("sat_flush_cnt", 128'(flush_cnt_o), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
